// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and jr interlocks, taken-branch flush,
// multi-cycle mult/div stall sequencing, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_ins,
  input  logic        id_ex_mem_read,
  input  logic        id_ex_reg_write,
  input  logic [4:0]  id_ex_dst,
  input  logic        jr,
  input  logic        branch_taken,
  input  logic        muldiv_start,
  input  logic        stat_clr,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic [15:0] stall_cycles
);

  typedef enum logic [0:0] {StRun, StMdBusy} state_e;

  state_e      state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic        done_q, done_d;
  logic [15:0] stall_q;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       uses_rt, load_use, jr_haz, hazard;

  assign opcode = if_id_ins[31:26];
  assign rs     = if_id_ins[25:21];
  assign rt     = if_id_ins[20:16];

  // R-type, beq, bne and sw read rt in ID/EX; everything else only reads rs.
  assign uses_rt  = (opcode == 6'h00) || (opcode == 6'h04) ||
                    (opcode == 6'h05) || (opcode == 6'h2B);
  assign load_use = id_ex_mem_read && (id_ex_dst != 5'd0) &&
                    ((id_ex_dst == rs) || (uses_rt && (id_ex_dst == rt)));
  assign jr_haz   = jr && id_ex_reg_write && (id_ex_dst != 5'd0) && (id_ex_dst == rs);
  assign hazard   = load_use || jr_haz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      md_cnt_q <= 6'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    done_d   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!branch_taken && !hazard && muldiv_start) begin
          state_d  = StMdBusy;
          md_cnt_d = 6'(MD_CYCLES - 2);
        end
      end
      StMdBusy: begin
        if (md_cnt_q == 6'd0) begin
          state_d = StRun;
          done_d  = 1'b1;
        end else begin
          md_cnt_d = md_cnt_q - 6'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    muldiv_busy  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (hazard) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      StMdBusy: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        muldiv_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'd0;
    end else if (stat_clr) begin
      stall_q <= 16'd0;
    end else if (!pc_en && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign muldiv_done  = done_q;
  assign stall_cycles = stall_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 32, meaning total stall cycles per mult/div operation; legal range 2..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port if_id_ins  input  32  instruction in ID; rs=[25:21], rt=[20:16], opcode=[31:26].
REQ-005 SHALL have port id_ex_mem_read  input  1  instruction in EX is a load.
REQ-006 SHALL have port id_ex_reg_write  input  1  instruction in EX writes a register.
REQ-007 SHALL have port id_ex_dst  input  5  destination register of the EX instruction.
REQ-008 SHALL have port jr  input  1  ID instruction is jr; it reads rs in ID.
REQ-009 SHALL have port branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-010 SHALL have port muldiv_start  input  1  ID instruction is mult/div requesting issue.
REQ-011 SHALL have port stat_clr  input  1  synchronous clear of stall_cycles.
REQ-012 SHALL have port pc_en  output  1  PC register update enable.
REQ-013 SHALL have port if_id_en  output  1  IF/ID register update enable.
REQ-014 SHALL have port if_id_flush  output  1  load NOP into IF/ID.
REQ-015 SHALL have port id_ex_bubble  output  1  load NOP into ID/EX.
REQ-016 SHALL have port muldiv_busy  output  1  mult/div in progress.
REQ-017 SHALL have port muldiv_done  output  1  registered one-cycle completion pulse.
REQ-018 SHALL have port stall_cycles  output  16  count of cycles with pc_en=0.

Function
REQ-019 SHALL implement FSM states RUN and MD_BUSY plus a 6-bit down-counter md_cnt.
REQ-020 uses_rt SHALL be 1 when opcode is 0x00, 0x04, 0x05 or 0x2B, else 0.
REQ-021 load_use SHALL be id_ex_mem_read & (id_ex_dst!=0) & (id_ex_dst==rs | (uses_rt & id_ex_dst==rt)).
REQ-022 jr_haz SHALL be jr & id_ex_reg_write & (id_ex_dst!=0) & (id_ex_dst==rs).
REQ-023 In RUN with branch_taken=1: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_bubble=1; load_use, jr_haz and muldiv_start SHALL be ignored that cycle.
REQ-024 In RUN, branch_taken=0, (load_use|jr_haz)=1: pc_en=0, if_id_en=0, id_ex_bubble=1, if_id_flush=0; muldiv_start ignored; state stays RUN.
REQ-025 In RUN, no branch, no hazard, muldiv_start=1: outputs as normal run (mult/div enters EX); next state MD_BUSY, md_cnt loaded MD_CYCLES-2.
REQ-026 In RUN with no condition above: pc_en=1, if_id_en=1, if_id_flush=0, id_ex_bubble=0.
REQ-027 In MD_BUSY: pc_en=0, if_id_en=0, id_ex_bubble=1, if_id_flush=0, muldiv_busy=1; branch_taken, hazards and muldiv_start SHALL be ignored.
REQ-028 In MD_BUSY, md_cnt SHALL decrement each cycle; when md_cnt==0, next state RUN and muldiv_done=1 for the following cycle only.
REQ-029 Stall length: one issue cycle in RUN plus exactly MD_CYCLES-1 MD_BUSY cycles; muldiv_done asserts in the first RUN cycle after.
REQ-030 All control outputs except muldiv_done and stall_cycles SHALL be combinational from state and inputs.
REQ-031 stall_cycles SHALL increment by 1 each cycle with pc_en=0, saturate at 0xFFFF, and take stat_clr priority (clear to 0) over increment.

Reset
REQ-032 rst=1 SHALL immediately force state RUN, md_cnt=0, muldiv_done=0, stall_cycles=0, regardless of clk.
REQ-033 Reset asserted mid-MD_BUSY SHALL abort the operation with no muldiv_done pulse.

Verification
REQ-034 Load-use: id_ex_mem_read=1, id_ex_dst=8, if_id_ins rs=8 -> pc_en=0, if_id_en=0, id_ex_bubble=1 one cycle; stall_cycles 0->1.
REQ-035 Zero register and sw rt: id_ex_dst=0 with rs=0 -> no stall; id_ex_dst=9, opcode 0x2B rt=9 -> stall; opcode 0x23 rt=9 -> no stall.
REQ-036 Branch priority: branch_taken=1 with load_use=1 and muldiv_start=1 -> if_id_flush=1, id_ex_bubble=1, pc_en=1, state stays RUN.
REQ-037 Mult/div, MD_CYCLES=4: muldiv_start pulse -> muldiv_busy high exactly 3 cycles, muldiv_done high 1 cycle after, stall_cycles +3.
REQ-038 Reset mid-MD_BUSY, then stall_cycles saturation: rst at cycle 2 -> muldiv_busy=0 immediately, no done; 65536+ stalled cycles -> stall_cycles holds 0xFFFF; stat_clr -> 0.
